// File: rtl/uart_package.sv
// Shared types and constants for the UART receive path.
package uart_package;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned UART_DATA_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head reads as zero when empty.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_intr.sv
// 8N1 UART receiver feeding a byte FIFO; holds intr while bytes are pending.
module uart_rx_intr
    import uart_package::*;
#(
    parameter int unsigned WAIT  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_rx,
    input  logic                   ack,
    output logic                   intr,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned CntW = $clog2(WAIT);
    localparam logic [CntW-1:0] CntFull = CntW'(WAIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(WAIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};

    logic [1:0]             sync_q, sync_d;
    rx_state_t              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_bit, fall, push, fifo_full, fifo_empty;

    // sync_q[0] is the first stage; the fall is seen as it enters the second.
    assign sync_d = {sync_q[0], uart_rx};
    assign rx_bit = sync_q[1];
    assign fall   = sync_q[1] & ~sync_q[0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = CntHalf;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_bit) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CntFull;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_bit, shift_q[UART_DATA_W-1:1]};
                    cnt_d   = CntFull;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (rx_bit) push        = 1'b1;
                    else        frame_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = IDLE;
        endcase
        // A push into a full FIFO only survives if ack frees a slot that cycle.
        overrun_d = overrun_q | (push & fifo_full & ~ack);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .Width (UART_DATA_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .reset_ni (reset),
        .push_i   (push),
        .pop_i    (ack),
        .wdata_i  (shift_q),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (rx_data)
    );

    assign intr      = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_intr.sv
// Directed bench for uart_rx_intr against a queue-based receive model.
module tb_uart_rx_intr;

    localparam int unsigned WAIT  = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       ack = 1'b0;
    logic       intr;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;

    uart_rx_intr #(
        .WAIT  (WAIT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .ack       (ack),
        .intr      (intr),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    bit         chk_en = 1'b0;

    logic [7:0] m_q[$];
    bit         m_ovr = 1'b0;
    bit         m_fe = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A byte arriving at a full queue is lost unless an ack pops first.
    task automatic model_step(input bit do_push, input logic [7:0] b, input bit do_ack);
        if (do_ack && m_q.size() > 0) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else                    m_ovr = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        m_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        reset = 1'b1;
    endtask

    // Drives one frame; the stop sample lands on edge 1+WAIT/2+9*WAIT from the start.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit ack_at_stop);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            uart_rx = bits[i];
            repeat (WAIT) tick();
        end
        uart_rx = stop_bit;
        repeat (WAIT / 2 + 1) tick();
        if (ack_at_stop) ack = 1'b1;
        tick();
        ack = 1'b0;
        model_step(stop_bit, b, ack_at_stop);
        if (!stop_bit) m_fe = 1'b1;
        tick();
        m_fe = 1'b0;
        repeat (WAIT / 2 - 2) tick();
        uart_rx = 1'b1;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        model_step(1'b0, 8'h00, 1'b1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("intr", 8'(intr), 8'(m_q.size() != 0));
            check("rx_data", rx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
            check("overrun", 8'(overrun), 8'(m_ovr));
            check("frame_err", 8'(frame_err), 8'(m_fe));
            if (frame_err === 1'b1) fe_cnt++;
        end
    end

    initial begin
        int fe_before;
        repeat (3) tick();
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_intr", 8'(intr), 8'h00);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_frame_err", 8'(frame_err), 8'h00);
        check("reset_overrun", 8'(overrun), 8'h00);
        tick();

        // Single byte with exact push latency.
        fork
            send_frame(8'h41, 1'b1, 1'b0);
            begin
                repeat (77) @(posedge clk);
                @(negedge clk);
                check("intr_before_77", 8'(intr), 8'h00);
                @(posedge clk);
                @(negedge clk);
                check("intr_at_77", 8'(intr), 8'h01);
                check("rx_data_at_77", rx_data, 8'h41);
            end
        join
        ack_pulse();
        check("single_pop_intr", 8'(intr), 8'h00);
        check("single_pop_data", rx_data, 8'h00);
        repeat (4) tick();

        // FIFO order.
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0);
        check("order_head", rx_data, 8'h12);
        ack_pulse();
        check("order_2", rx_data, 8'h34);
        ack_pulse();
        check("order_3", rx_data, 8'h56);
        ack_pulse();
        check("order_empty", 8'(intr), 8'h00);
        repeat (4) tick();

        // Overrun without ack.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("ovr_set", 8'(overrun), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop", rx_data, 8'(i));
            ack_pulse();
        end
        check("ovr_drained", 8'(intr), 8'h00);
        check("ovr_sticky", 8'(overrun), 8'h01);
        tick();
        do_reset();
        tick();

        // Ack coincident with the fifth stop sample frees a slot.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("ack_stop_no_ovr", 8'(overrun), 8'h00);
        for (int i = 2; i <= 5; i++) begin
            check("ack_stop_pop", rx_data, 8'(i));
            ack_pulse();
        end
        check("ack_stop_empty", 8'(intr), 8'h00);
        repeat (4) tick();

        // Framing error.
        fe_before = fe_cnt;
        send_frame(8'h77, 1'b0, 1'b0);
        repeat (4) tick();
        check("fe_pulses", 8'(fe_cnt - fe_before), 8'h01);
        check("fe_no_intr", 8'(intr), 8'h00);

        // Three-cycle glitch is a false start.
        fe_before = fe_cnt;
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        check("glitch_no_fe", 8'(fe_cnt - fe_before), 8'h00);
        check("glitch_no_intr", 8'(intr), 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("after_glitch", rx_data, 8'h5A);
        ack_pulse();
        repeat (4) tick();

        // Reset during the data bits of 0xFF.
        uart_rx = 1'b0;
        repeat (WAIT) tick();
        uart_rx = 1'b1;
        repeat (3 * WAIT) tick();
        do_reset();
        repeat (8 * WAIT) tick();
        check("rst_mid_no_push", 8'(intr), 8'h00);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("after_rst_data", rx_data, 8'hA5);
        ack_pulse();

        // Spurious acks while empty.
        ack_pulse();
        ack_pulse();
        check("spurious_intr", 8'(intr), 8'h00);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("spurious_data", rx_data, 8'h3C);
        ack_pulse();
        check("spurious_empty", 8'(intr), 8'h00);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_intr.md
# uart_rx_intr

Serial receive front end for `mother_board`. It deserialises 8N1 frames from `uart_rx` and buffers the bytes in a small FIFO. While data is pending it holds an interrupt request to `cpu`. The CPU's `ack` pulse, produced by `w_intr` to intr[0], pops one byte, so this block feeds the CPU interrupt path directly upstream of `cpu`.

## Interface
- `WAIT`, default 8: clock cycles per bit. Must be even and ≥ 4; same meaning as the `mother_board` WAIT parameter.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `uart_rx`  in  1  asynchronous serial line; idles high.
- `ack`  in  1  one-cycle pulse from `cpu`; pops the FIFO head.
- `intr`  out  1  high while the FIFO is non-empty.
- `rx_data`  out  8  FIFO head byte; valid while `intr`=1, 8'h00 when empty.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for a bad stop bit.
- `overrun`  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- **Input synchroniser:** 2-flop synchroniser on `uart_rx`, reset value 1. Edge detect compares the synchronised value with its previous value.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter (0..WAIT-1) and a bit index (0..7) run alongside.
  - IDLE → START on a synchronised falling edge. The counter loads WAIT/2-1.
  - START, at counter 0: sample the line. If 1 (false start), go to IDLE with no flags. If 0, go to DATA with counter WAIT-1 and index 0.
  - DATA, at counter 0: shift the sample in LSB first. After index 7, go to STOP with counter WAIT-1.
  - STOP, at counter 0: if the sample is 1, push the byte. If 0, pulse `frame_err` and discard the byte. Either way, go to IDLE.
  - In every other cycle the counter decrements.
- **FIFO pointers:** read/write pointers are log2(DEPTH)+1 bits wide. Full and empty are decided from the MSB comparison.
- **Push when full:** the byte is dropped, `overrun` goes to 1, and the FIFO contents are unchanged.
- **`ack` when empty:** ignored; no pointer moves.
- **Push and pop in the same cycle:** both take effect, and occupancy is unchanged. When the FIFO is full, a simultaneous `ack` frees the slot, so the push succeeds and `overrun` is not set.
- **`ack` held high for N cycles:** pops up to N entries. The CPU is responsible for pulsing it.
- **`overrun`:** cleared only by reset.
- **Reset values:** FSM = IDLE, pointers 0, `intr`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0. Reset mid-frame abandons the frame, and no push occurs.

## Timing
- **Cycle reference:** cycle 0 is the first rising edge that registers `uart_rx`=0 in flop 1. The synchronised fall is visible at cycle 1, and the edge is detected in that cycle.
- **Sample points:**
  - start bit at cycle 1+WAIT/2;
  - data bit k at cycle 1+WAIT/2+(k+1)·WAIT;
  - stop bit at cycle 1+WAIT/2+9·WAIT (cycle 77 for WAIT=8).
- **Push latency:** the push happens on the stop sample edge. `intr` and `rx_data` update combinationally from the registered pointers, so they are visible from that edge (cycle 77 for WAIT=8).
- **Pop latency:** `ack` sampled at edge t updates `rx_data` and `intr` from edge t.
- **Back-to-back frames:** a new start edge is accepted in the first IDLE cycle after STOP. This tolerates a stop bit of exactly WAIT cycles.
- **`frame_err`:** asserted for exactly the one cycle following the stop sample edge.

## Structure
- **`uart_package`:** typedef `rx_state_t` enum {IDLE, START, DATA, STOP}; localparam `UART_DATA_W` = 8.
- **Sub-module `sync_fifo`:** parameterised width/depth, with push/pop/full/empty/head. `uart_rx_intr` instantiates one with width 8. Expected size is about 200 lines total.

## Test plan
- **Single byte:** WAIT=8, drive frame 0x41 (bits 0 start,1,0,0,0,0,0,1,0,1 stop, 8 cycles each) → `intr` rises at cycle 77, `rx_data`=0x41. One `ack` pulse → `intr`=0, `rx_data`=0x00.
- **FIFO order:** send 0x12, 0x34, 0x56 back to back with no acks → `rx_data` stays 0x12. Three `ack` pulses yield 0x34, 0x56, then empty.
- **Overrun:** send DEPTH+1=5 bytes 0x01..0x05 with no ack → `overrun`=1, and the FIFO pops 0x01..0x04 only. Repeat with `ack` coincident with the 5th stop sample → `overrun` stays 0 and 0x05 is retained.
- **Framing error and false start:**
  - Frame with the stop bit driven 0 → a one-cycle `frame_err` pulse, `intr` stays 0.
  - A 3-cycle low glitch → no flags, FSM returns to IDLE.
- **Reset mid-frame and spurious ack:**
  - `reset`=0 for 1 cycle during the DATA bits of 0xFF → no push. The next clean 0xA5 frame is received correctly.
  - `ack` while empty → pointers unchanged.
